// File: rtl/tpu_ctrl_pkg.sv
// Shared encodings and width helpers for the MMU sequencing controllers.
package tpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } drain_state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  // Sized so that 2^addr_w rows plus the full staircase never overflow.
  function automatic int cyc_cnt_w(input int addr_w, input int width);
    return addr_w + 1 + $clog2(width) + 1;
  endfunction

  function automatic int row_cnt_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register used to re-align one skewed array column.
module skew_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = ^{clk, reset, en};
    assign q = d;
  end else begin : g_shift
    logic [DATA_W-1:0] stg [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
      end else if (en) begin
        stg[0] <= d;
        for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
      end
    end

    assign q = stg[DEPTH-1];
  end

endmodule

// File: rtl/output_deskew_control.sv
// Drain-side staircase enable, column de-skew and output buffer write sequencer.
//
//   state     | meaning
//   ----------+-----------------------------------------------------
//   ST_IDLE   | waiting for active; latches row count and base address
//   ST_FILL   | staircase col_en running, delay lines shifting
//   ST_DRAIN  | last aligned row being written
//   ST_FINISH | one-cycle done pulse
module output_deskew_control
  import tpu_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [ADDR_W:0]         num_rows,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [WIDTH*DATA_W-1:0] col_data,
  output logic [WIDTH-1:0]        col_en,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [WIDTH*DATA_W-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int CNT_W = cyc_cnt_w(ADDR_W, WIDTH);
  localparam int ROW_W = row_cnt_w(ADDR_W);

  drain_state_t            state_q, state_d;
  logic [CNT_W-1:0]        cyc_q;
  logic [ROW_W-1:0]        row_q;
  logic [ROW_W-1:0]        num_q;
  logic [ADDR_W-1:0]       base_q;
  logic [CNT_W-1:0]        n_c;
  logic                    last_fill;
  logic                    write_nxt;
  logic [WIDTH*DATA_W-1:0] aligned;

  assign n_c  = CNT_W'(num_q);
  assign busy = (state_q == ST_FILL) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_FINISH);

  // cyc_q counts cycles from T0; the last column's window closes at N+WIDTH-2.
  assign last_fill = (cyc_q == n_c + CNT_W'(WIDTH - 2));
  assign write_nxt = (state_q == ST_FILL) &&
                     (cyc_q >= CNT_W'(WIDTH - 1)) &&
                     (cyc_q <  n_c + CNT_W'(WIDTH - 1));

  always_comb begin
    col_en = '0;
    if (state_q == ST_FILL) begin
      for (int j = 0; j < WIDTH; j++) begin
        col_en[j] = (cyc_q >= CNT_W'(j)) && (cyc_q < n_c + CNT_W'(j));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (active) state_d = (num_rows != '0) ? ST_FILL : ST_FINISH;
      ST_FILL:   if (last_fill) state_d = ST_DRAIN;
      ST_DRAIN:  state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_q  <= '0;
      row_q  <= '0;
      num_q  <= '0;
      base_q <= '0;
    end else begin
      if (state_q == ST_IDLE && active) begin
        num_q  <= num_rows;
        base_q <= base_addr;
        cyc_q  <= '0;
        row_q  <= '0;
      end else if (busy) begin
        cyc_q <= cyc_q + CNT_W'(1);
      end
      if (write_nxt) row_q <= row_q + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= write_nxt;
      if (write_nxt) begin
        wr_addr <= base_q + row_q[ADDR_W-1:0];
        wr_data <= aligned;
      end
    end
  end

  // Gating with col_en keeps off-window samples out of the delay lines.
  for (genvar j = 0; j < WIDTH; j++) begin : g_col
    logic [DATA_W-1:0] col_in;
    assign col_in = col_en[j] ? col_data[j*DATA_W +: DATA_W] : '0;

    skew_delay_line #(
      .DEPTH  (WIDTH - 1 - j),
      .DATA_W (DATA_W)
    ) u_dly (
      .clk   (clk),
      .reset (reset),
      .en    (busy),
      .d     (col_in),
      .q     (aligned[j*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_output_deskew_control.sv
// Directed bench for output_deskew_control at WIDTH=4, DATA_W=8, ADDR_W=4.
module tb_output_deskew_control;

  localparam int WIDTH  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    active = 1'b0;
  logic [ADDR_W:0]         num_rows = '0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [WIDTH*DATA_W-1:0] col_data = '0;
  logic [WIDTH-1:0]        col_en;
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WIDTH*DATA_W-1:0] wr_data;
  logic                    busy;
  logic                    done;

  int n_chk  = 0;
  int n_pass = 0;

  output_deskew_control #(
    .WIDTH  (WIDTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .num_rows  (num_rows),
    .base_addr (base_addr),
    .col_data  (col_data),
    .col_en    (col_en),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  function automatic logic [31:0] row_word(input int r);
    logic [31:0] w;
    for (int j = 0; j < WIDTH; j++) w[j*8 +: 8] = 8'(16 * r + j);
    return w;
  endfunction

  // Column j carries row t-j in cycle T0+t; junk outside its window.
  task automatic drive_cols(input int t, input int n);
    for (int j = 0; j < WIDTH; j++) begin
      if (t - j >= 0 && t - j < n) col_data[j*8 +: 8] = 8'(16 * (t - j) + j);
      else                         col_data[j*8 +: 8] = 8'hA5;
    end
  endtask

  task automatic check_cycle(input int t, input int n, input int base);
    logic [3:0] e;
    logic       we;
    for (int j = 0; j < WIDTH; j++) e[j] = (t >= j) && (t < j + n);
    we = (n > 0) && (t >= 4) && (t < 4 + n);
    chk("col_en", 64'(col_en), 64'(e));
    chk("wr_en", 64'(wr_en), 64'(we));
    if (we) begin
      chk("wr_addr", 64'(wr_addr), 64'((base + t - 4) % 16));
      chk("wr_data", 64'(wr_data), 64'(row_word(t - 4)));
    end
    chk("done", 64'(done), 64'((n == 0) ? (t == 0) : (t == 4 + n)));
    chk("busy", 64'(busy), 64'((n > 0) && (t < 4 + n)));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_col_en"}, 64'(col_en), 64'(0));
    chk({tag, "_wr_en"}, 64'(wr_en), 64'(0));
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'(0));
    chk({tag, "_wr_data"}, 64'(wr_data), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
  endtask

  // Called one offset into an IDLE cycle; returns one offset into the cycle after done.
  task automatic run(input int n, input int base, input bit poke, input int rst_at);
    logic [3:0] tbl [0:6];
    int last;
    tbl = '{4'h1, 4'h3, 4'h7, 4'hE, 4'hC, 4'h8, 4'h0};
    last = (n == 0) ? 0 : 4 + n;
    active    = 1'b1;
    num_rows  = 5'(n);
    base_addr = 4'(base);
    for (int t = 0; t <= last; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        active    = 1'b0;
        num_rows  = 5'd31;
        base_addr = 4'd7;
      end
      if (poke && t == 2) begin
        active   = 1'b1;
        num_rows = 5'd1;
      end
      if (poke && t == 3) active = 1'b0;
      drive_cols(t, n);
      if (t == rst_at) begin
        reset = 1'b0;
        #1;
        check_zero("rst_mid");
        return;
      end
      check_cycle(t, n, base);
      if (n == 3 && t < 7) chk("col_en_tbl", 64'(col_en), 64'(tbl[t]));
    end
    @(posedge clk); #1;
    drive_cols(-10, 0);
    chk("idle_done", 64'(done), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_wr_en", 64'(wr_en), 64'(0));
    chk("idle_col_en", 64'(col_en), 64'(0));
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    run(3, 2, 1'b1, -1);
    run(2, 9, 1'b0, -1);
    repeat (2) @(posedge clk);
    #1;
    run(8, 0, 1'b0, -1);
    run(4, 14, 1'b0, -1);
    run(0, 7, 1'b0, -1);
    run(3, 1, 1'b0, 5);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_hold_done", 64'(done), 64'(0));
      chk("rst_hold_busy", 64'(busy), 64'(0));
    end
    reset = 1'b1;
    @(posedge clk); #1;
    run(1, 3, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/output_deskew_control.md
Name: output_deskew_control

Overview:
- Drain-side counterpart of the MMU input staircase loader.
- Results leave the bottom of the systolic array skewed: column j's element for result row r arrives one cycle after column j-1's.
- This block generates the per-column staircase enable for the accumulator outputs and de-skews the columns with per-column delay lines.
- It writes each aligned row to the output buffer at consecutive addresses, then pulses done.

Parameters:
- WIDTH, 16, number of MMU columns.
- DATA_W, 16, bits per column result.
- ADDR_W, 8, output buffer address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; low clears all state immediately.
- active  in  1  start request, sampled only in IDLE.
- num_rows  in  ADDR_W+1  result rows to drain, 0..2^ADDR_W; latched with active.
- base_addr  in  ADDR_W  first write address; latched with active.
- col_data  in  WIDTH*DATA_W  skewed array outputs; column j at [j*DATA_W +: DATA_W].
- col_en  out  WIDTH  per-column output-shift enable (staircase).
- wr_en  out  1  output buffer write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  WIDTH*DATA_W  aligned row, same column packing as col_data.
- busy  out  1  high in FILL/DRAIN.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: col_en=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0. State=IDLE, counters=0, all delay-line stages=0.
- States:
  - IDLE: active=1 latches N=num_rows and base_addr. Goes to FILL if N>0, else to FINISH.
  - FILL: runs staircase and delay lines. Goes to DRAIN when the last column's enable window ends.
  - DRAIN: flushes the remaining aligned rows to writes.
  - FINISH: done=1 for one cycle, then back to IDLE.
- Timing: T0 = first FILL cycle, i.e. the cycle after active is sampled.
- col_en:
  - col_en[j]=1 on cycles T0+j .. T0+j+N-1.
  - Ramp-up is shift-left-plus-one (0001, 0011, ...). The hold is all-ones when N≥WIDTH. Ramp-down is shift-left (...1110, ...1100, ...).
  - Last nonzero col_en is cycle T0+N+WIDTH-2.
- Input sampling: col_data column j is sampled on every cycle col_en[j]=1. Row r of column j is sampled at cycle T0+r+j.
- De-skew:
  - Column j passes through a delay line of depth WIDTH-1-j. Column WIDTH-1 has depth 0.
  - Delay lines shift every cycle while busy.
  - Row r is aligned in the output register at cycle T0+r+WIDTH-1.
- Writes:
  - wr_en=1 on cycles T0+WIDTH+r for r=0..N-1, with wr_addr=(base_addr+r) mod 2^ADDR_W. Address wraps silently.
  - wr_data holds row r in that cycle. wr_en is never high for more than N cycles.
- done: high at cycle T0+WIDTH+N for one cycle, the cycle after the last write. busy falls in the same cycle.
- N=0: FINISH at T0. done at T0, no col_en, no writes.
- active while busy or in FINISH: ignored; no re-latch.
- Back-to-back: active is sampled again in IDLE the cycle after done.
- reset asserted mid-operation: all outputs and state return to reset values asynchronously. Partial rows are discarded and no done is issued.
- Counters:
  - Cycle counter width ADDR_W+1+clog2(WIDTH)+1. It must not overflow at N=2^ADDR_W.
  - Row counter width ADDR_W+1.

Decomposition:
- Shared package tpu_ctrl_pkg: state encoding (IDLE, FILL, DRAIN, FINISH) and width helper localparams (counter widths).
- Sub-module skew_delay_line:
  - Parameters DEPTH and DATA_W; a DEPTH-stage shift register with async active-low clear.
  - DEPTH=0 is a passthrough.
  - Instantiated once per column via generate.

Test Plan:
- Tests use WIDTH=4, DATA_W=8, ADDR_W=4.
- Basic drain: active with N=3, base_addr=2; column j at cycle T0+r+j drives 0x10*r+j.
  - col_en sequence 0001, 0011, 0111, 1110, 1100, 1000, 0000.
  - wr_en at T0+4..T0+6, addresses 2, 3, 4, wr_data rows {03,02,01,00}, {13,12,11,10}, {23,22,21,20}.
  - done at T0+7.
- Long run: N=8 -> col_en=1111 on T0+3..T0+7; 8 consecutive writes; done at T0+12.
- Address wrap: N=4, base_addr=14 -> wr_addr 14, 15, 0, 1.
- Zero rows: N=0 -> done at T0, wr_en and col_en never asserted.
- Ignore and reset:
  - active pulsed again at T0+2 -> no effect on the sequence.
  - Separate run: reset pulled low at T0+5 -> all outputs 0 immediately, no done. A fresh N=1 run after release completes with one write at T0'+4.
- Back-to-back: second active in the cycle after done, N=2 -> correct col_en and writes with no stale data from the first run.
